muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. Accepts MULT/MULTU/DIV/DIVU requests from the EX stage and runs an iterative restoring divider and a multiplier. It raises a stall while the operation is in flight and delivers a one-cycle HI/LO write with the 64-bit result. Sits beside the ALU; the decoded ALU_DIV/DIVU/MULT/MULTU operations select its `op`.

---
 rtl/muldiv_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
//============================================================================
// Module   : muldiv_ctrl
// Function : Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//            Iterative restoring divider (one quotient bit per cycle) and a
//            multiplier, with a pipeline stall (busy) while an operation is
//            in flight and a one-cycle HI/LO write strobe (done).
// Options  : `define MUL_ITER_EN selects a radix-2 shift-add multiplier
//            (32 MUL_RUN cycles) instead of a single-cycle registered '*'.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module muldiv_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DIV_RUN = 3'd1,
        S_DIV_FIX = 3'd2,
`ifdef MUL_ITER_EN
        S_MUL_RUN = 3'd3,
`else
        S_MUL_S1  = 3'd4,
`endif
        S_MUL_FIX = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_signed;    // operation is MULT or DIV
    logic              r_sa;        // raw sign of a (meaningful when r_signed)
    logic              r_sb;        // raw sign of b
    logic              r_bzero;     // divisor was zero
    logic [31:0]       r_a_raw;     // original a, returned as HI on divide-by-zero
    logic [31:0]       r_mag_a;     // |a| for signed ops, a otherwise
    logic [31:0]       r_mag_b;     // |b| for signed ops, b otherwise
    logic [31:0]       r_quo;       // dividend shifting out / quotient shifting in
    logic [31:0]       r_rem;       // partial remainder
    logic [63:0]       r_prod;      // unsigned magnitude product
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_accept;
    logic              w_in_flight;
    logic              w_signed;
    logic [31:0]       w_mag_a;
    logic [31:0]       w_mag_b;
    logic [32:0]       w_shift;
    logic [32:0]       w_diff;
    logic              w_div_ge;
    logic [31:0]       w_div_lo;
    logic [31:0]       w_div_hi;
    logic [63:0]       w_prod_fix;
`ifdef MUL_ITER_EN
    logic [32:0]       w_sum;
`endif

    // Request acceptance and operand magnitude extraction
    assign w_accept = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_signed = ~op[0];
    assign w_mag_a  = (w_signed & a[31]) ? (~a + 32'd1) : a;
    assign w_mag_b  = (w_signed & b[31]) ? (~b + 32'd1) : b;

`ifdef MUL_ITER_EN
    assign w_in_flight = (r_state == S_DIV_RUN) | (r_state == S_DIV_FIX) |
                         (r_state == S_MUL_RUN) | (r_state == S_MUL_FIX);
`else
    assign w_in_flight = (r_state == S_DIV_RUN) | (r_state == S_DIV_FIX) |
                         (r_state == S_MUL_S1)  | (r_state == S_MUL_FIX);
`endif

    assign busy = ~rst & (w_accept | w_in_flight);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Restoring divide step: shift one dividend bit in, subtract if it fits
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_mag_b};
    assign w_div_ge = ~w_diff[32];

`ifdef MUL_ITER_EN
    // Shift-add multiply step: conditionally add multiplicand to upper half
    assign w_sum = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mag_a} : 33'd0);
`endif

    // Sign fix-up of divide result, with divide-by-zero override
    always_comb begin
        w_div_lo = r_quo;
        w_div_hi = r_rem;
        if (r_bzero) begin
            w_div_lo = 32'hFFFF_FFFF;
            w_div_hi = r_a_raw;
        end else begin
            if (r_signed & (r_sa ^ r_sb)) begin
                w_div_lo = ~r_quo + 32'd1;
            end
            if (r_signed & r_sa) begin
                w_div_hi = ~r_rem + 32'd1;
            end
        end
    end

    // Sign fix-up of the magnitude product for MULT
    always_comb begin
        w_prod_fix = r_prod;
        if (r_signed & (r_sa ^ r_sb)) begin
            w_prod_fix = ~r_prod + 64'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (op[1]) begin
                            w_next = S_DIV_RUN;
                        end else begin
`ifdef MUL_ITER_EN
                            w_next = S_MUL_RUN;
`else
                            w_next = S_MUL_S1;
`endif
                        end
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_DIV_RUN: begin
                    if (r_cnt == c_cnt_last) begin
                        w_next = S_DIV_FIX;
                    end
                end
                S_DIV_FIX: w_next = S_DONE;
`ifdef MUL_ITER_EN
                S_MUL_RUN: begin
                    if (r_cnt == c_cnt_last) begin
                        w_next = S_MUL_FIX;
                    end
                end
`else
                S_MUL_S1:  w_next = S_MUL_FIX;
`endif
                S_MUL_FIX: w_next = S_DONE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Iteration counter shared by the divider and the iterative multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (flush | w_accept) begin
            r_cnt <= '0;
`ifdef MUL_ITER_EN
        end else if ((r_state == S_DIV_RUN) | (r_state == S_MUL_RUN)) begin
`else
        end else if (r_state == S_DIV_RUN) begin
`endif
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand capture on accept and per-cycle arithmetic datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signed <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            r_a_raw  <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_prod   <= '0;
        end else if (w_accept) begin
            r_signed <= w_signed;
            r_sa     <= a[31];
            r_sb     <= b[31];
            r_bzero  <= (b == 32'd0);
            r_a_raw  <= a;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_quo    <= w_mag_a;
            r_rem    <= '0;
            r_prod   <= {32'd0, w_mag_b};
        end else begin
            case (r_state)
                S_DIV_RUN: begin
                    r_rem <= w_div_ge ? w_diff[31:0] : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_div_ge};
                end
`ifdef MUL_ITER_EN
                S_MUL_RUN: r_prod <= {w_sum, r_prod[31:1]};
`else
                S_MUL_S1:  r_prod <= {32'd0, r_mag_a} * {32'd0, r_mag_b};
`endif
                default: ;
            endcase
        end
    end

    // HI/LO result registers, loaded on the transition into DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush) begin
            if (r_state == S_DIV_FIX) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end else if (r_state == S_MUL_FIX) begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//============================================================================
// Module   : tb_muldiv_ctrl
// Function : Self-checking bench for muldiv_ctrl: directed cases plus
//            randomized operations against an arithmetic reference model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_muldiv_ctrl;

`ifdef MUL_ITER_EN
    localparam int MUL_LAT = 34;
`else
    localparam int MUL_LAT = 3;
`endif
    localparam int DIV_LAT = 34;
    localparam int N_RAND  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl #(.DIV_ITERS(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference model: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
        longint sp;
        int     sa, sb, q, r;
        logic [63:0] up;
        case (f_op)
            2'b00: begin
                sp = longint'($signed(f_a)) * longint'($signed(f_b));
                return sp;
            end
            2'b01: begin
                up = {32'd0, f_a} * {32'd0, f_b};
                return up;
            end
            2'b10: begin
                if (f_b == 32'd0) return {f_a, 32'hFFFF_FFFF};
                if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = f_a; sb = f_b;
                q = sa / sb; r = sa % sb;
                return {r, q};
            end
            default: begin
                if (f_b == 32'd0) return {f_a, 32'hFFFF_FFFF};
                return {f_a % f_b, f_a / f_b};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] f_op);
        return f_op[1] ? DIV_LAT : MUL_LAT;
    endfunction

    // Present a request at the current negedge; busy must rise combinationally
    task automatic issue(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b, input string tag);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept busy: got %b expected 1", tag, busy);
        end
    endtask

    // Track an accepted operation to its DONE cycle, optionally chaining the next
    task automatic follow(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input bit chain, input logic [1:0] n_op, input logic [31:0] n_a,
                          input logic [31:0] n_b, input string tag);
        logic [63:0] exp;
        int lat;
        exp = ref_result(t_op, t_a, t_b);
        lat = latency(t_op);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            checks++;
            if (done !== 1'(c == lat)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, c, done, (c == lat));
            end
            if (c < lat) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: got %b expected 1", tag, c, busy);
                end
                if (c == lat - 1) begin
                    checks++;
                    if ({hi, lo} !== {m_hi, m_lo}) begin
                        errors++;
                        $display("FAIL %s hold: got %h_%h expected %h_%h", tag, hi, lo, m_hi, m_lo);
                    end
                end
            end else begin
                checks++;
                if (hi !== exp[63:32]) begin
                    errors++;
                    $display("FAIL %s hi op=%0d a=%h b=%h: got %h expected %h", tag, t_op, t_a, t_b, hi, exp[63:32]);
                end
                checks++;
                if (lo !== exp[31:0]) begin
                    errors++;
                    $display("FAIL %s lo op=%0d a=%h b=%h: got %h expected %h", tag, t_op, t_a, t_b, lo, exp[31:0]);
                end
                m_hi = exp[63:32];
                m_lo = exp[31:0];
                if (chain) begin
                    issue(n_op, n_a, n_b, tag);
                end else begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s busy in DONE: got %b expected 0", tag, busy);
                    end
                end
            end
        end
    endtask

    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b, input string tag);
        @(negedge clk);
        issue(t_op, t_a, t_b, tag);
        follow(t_op, t_a, t_b, 1'b0, 2'b00, 32'd0, 32'd0, tag);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_div;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(2'b11, 32'h1234_5678, 32'd0, "divu_by_zero");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by_zero");
        run_op(2'b10, 32'd100, 32'hFFFF_FFFD, "div_pos_neg");
    endtask

    task automatic test_mul;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_ones");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ones");
        run_op(2'b00, 32'h8000_0000, 32'd3, "mult_min");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "b2b");
        follow(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2'b01, 32'd3, 32'd5, "b2b_div_ovf");
        follow(2'b01, 32'd3, 32'd5, 1'b0, 2'b00, 32'd0, 32'd0, "b2b_multu");
    endtask

    task automatic test_flush;
        logic [31:0] ph, pl;
        bit seen;
        ph = m_hi; pl = m_lo;
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7, "flush");
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL flush idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if ({hi, lo} !== {ph, pl}) begin
            errors++;
            $display("FAIL flush hold: got %h_%h expected %h_%h", hi, lo, ph, pl);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done | busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush no done: got activity=1 expected 0");
        end
        // Flush landing in the DONE cycle keeps that cycle's done and result
        @(negedge clk);
        issue(2'b01, 32'd6, 32'd7, "flush_done");
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        flush = 1'b1;
        #1;
        checks++;
        if ({done, lo} !== {1'b1, 32'd42}) begin
            errors++;
            $display("FAIL flush_done: got done=%b lo=%h expected 1 0000002a", done, lo);
        end
        @(negedge clk);
        flush = 1'b0;
        m_hi = 32'd0; m_lo = 32'd42;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL flush_done after: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_div;
        @(negedge clk);
        issue(2'b10, 32'd12345, 32'd17, "rst_mid");
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op(2'b01, 32'd11, 32'd13, "after_rst");
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [1:0]  r_ops [N_RAND];
        logic [31:0] r_as  [N_RAND];
        logic [31:0] r_bs  [N_RAND];
        bit          r_ch  [N_RAND];
        int nx;
        for (int i = 0; i < N_RAND; i++) begin
            r_ops[i] = 2'($urandom_range(0, 3));
            r_as[i]  = pick();
            r_bs[i]  = pick();
            r_ch[i]  = ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < N_RAND; i++) begin
            nx = (i < N_RAND - 1) ? i + 1 : i;
            if (i == 0 || !r_ch[i]) begin
                @(negedge clk);
                issue(r_ops[i], r_as[i], r_bs[i], "rand");
            end
            follow(r_ops[i], r_as[i], r_bs[i], (i < N_RAND - 1) && r_ch[nx],
                   r_ops[nx], r_as[nx], r_bs[nx], "rand");
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
